// File: rtl/doa_pkg.sv
// Shared definitions for the DOA correlation datapath.
//   CORR_IN_W / CORR_ACC_W / CORR_NUM_CH : default lane widths and lane count
//   frame_state_t                        : per-frame accumulation state
//   sat_kind_t / sat_add                 : saturating-add decision for a lane
package doa_pkg;

    localparam int CORR_IN_W   = 25;
    localparam int CORR_ACC_W  = 30;
    localparam int CORR_NUM_CH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,   // no sample of the current frame accepted yet
        ST_ACCUM = 1'b1    // at least one sample accumulated
    } frame_state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_kind_t;

    // Classifies an (ACC_W+1)-bit two's-complement sum by its two top bits.
    // With one guard bit, the sum fits ACC_W bits exactly when both top bits
    // agree; 01 means it went above the positive limit, 10 below the negative.
    function automatic sat_kind_t sat_add(input logic [1:0] sum_top);
        sat_kind_t kind;
        case (sum_top)
            2'b01:   kind = SAT_POS;
            2'b10:   kind = SAT_NEG;
            default: kind = SAT_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/accum_sat_lane.sv
// One saturating accumulator lane.
//   i_clk, i_reset : clock, synchronous active-high reset
//   ce             : accept din into the accumulator this cycle
//   clr            : with ce, the frame ends here; register returns to 0
//   din            : signed sample, IN_W bits
//   acc            : saturated sum of the register and din (value the frame
//                    would hold including din), ACC_W bits
//   clip           : acc was clamped in this addition
module accum_sat_lane
    import doa_pkg::*;
#(
    parameter int IN_W  = CORR_IN_W,
    parameter int ACC_W = CORR_ACC_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             ce,
    input  logic             clr,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc,
    output logic             clip
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;
    sat_kind_t        kind;

    always_comb begin
        sum  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
        kind = sat_add(sum[ACC_W -: 2]);
        clip = (kind != SAT_NONE);
        case (kind)
            SAT_POS: acc = {1'b0, {(ACC_W-1){1'b1}}};
            SAT_NEG: acc = {1'b1, {(ACC_W-1){1'b0}}};
            default: acc = sum[ACC_W-1:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q <= '0;
        end else if (ce) begin
            acc_q <= clr ? '0 : acc;
        end
    end

endmodule

// File: rtl/accum_corr_mc.sv
// Multi-channel frame accumulator for correlation products. Sums NUM_CH
// signed lanes over a frame (ended by i_last, or after FRAME_LEN accepted
// samples when FRAME_LEN > 0) and publishes one saturated result per frame.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_data         : NUM_CH packed signed samples, lane k at [k*IN_W +: IN_W]
//   i_valid/i_last : sample valid, final sample of frame
//   o_ready        : input accepted when i_valid & o_ready
//   o_accum        : NUM_CH packed signed frame sums
//   o_count        : samples in the published frame (saturating)
//   o_sat          : per-lane "clipped at least once in the frame"
//   o_valid        : result register holds an unconsumed frame
//   i_ready        : downstream takes the result when o_valid & i_ready
//   o_state        : current frame state (debug visibility)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; valid, once raised, holds its data until that transfer. Input
// ready is combinational from the output side, so a full result register
// still accepts a sample in a cycle where it is being drained.
module accum_corr_mc
    import doa_pkg::*;
#(
    parameter int NUM_CH    = CORR_NUM_CH,
    parameter int IN_W      = CORR_IN_W,
    parameter int ACC_W     = CORR_ACC_W,
    parameter int FRAME_LEN = 0,
    parameter int CNT_W     = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_CH*IN_W-1:0]  i_data,
    input  logic                    i_valid,
    input  logic                    i_last,
    output logic                    o_ready,
    output logic [NUM_CH*ACC_W-1:0] o_accum,
    output logic [CNT_W-1:0]        o_count,
    output logic [NUM_CH-1:0]       o_sat,
    output logic                    o_valid,
    input  logic                    i_ready,
    output frame_state_t            o_state
);

    localparam logic [CNT_W:0] FRAME_LEN_W = (CNT_W+1)'(FRAME_LEN);

    logic                    accept;
    logic                    eof;
    logic                    len_hit;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_inc;
    logic [NUM_CH-1:0]       sat_q;
    logic [NUM_CH-1:0]       clip;
    logic [NUM_CH*ACC_W-1:0] acc_nxt;
    frame_state_t            state_q;
    frame_state_t            state_d;

    assign o_ready = ~o_valid | i_ready;
    assign accept  = i_valid & o_ready;

    // Counter holds at all-ones rather than wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Compared one bit wider so a saturated counter never aliases FRAME_LEN.
    assign len_hit = (FRAME_LEN != 0) &&
                     (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == FRAME_LEN_W);
    assign eof     = accept & (i_last | len_hit);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        accum_sat_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .ce      (accept),
            .clr     (eof),
            .din     (i_data[k*IN_W +: IN_W]),
            .acc     (acc_nxt[k*ACC_W +: ACC_W]),
            .clip    (clip[k])
        );
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = eof ? ST_IDLE : ST_ACCUM;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= eof ? '0 : cnt_inc;
                sat_q <= eof ? '0 : (sat_q | clip);
            end
        end
    end

    // Result register: a new frame end reloads it even while draining, so a
    // simultaneous drain and reload keeps o_valid high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_accum <= '0;
            o_count <= '0;
            o_sat   <= '0;
            o_valid <= 1'b0;
        end else if (eof) begin
            o_accum <= acc_nxt;
            o_count <= cnt_inc;
            o_sat   <= sat_q | clip;
            o_valid <= 1'b1;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_accum_corr_mc.sv
module tb_accum_corr_mc;
    import doa_pkg::*;

    localparam int NC = 4;
    localparam int IW = 25;
    localparam int AW = 30;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT A: FRAME_LEN = 0 ----------------
    logic [NC*IW-1:0] d_a;
    logic             v_a, l_a, r_a, rdy_a, ov_a;
    logic [NC*AW-1:0] acc_a;
    logic [CW-1:0]    cnt_a;
    logic [NC-1:0]    sat_a;
    frame_state_t     st_a;

    accum_corr_mc #(.NUM_CH(NC), .IN_W(IW), .ACC_W(AW), .FRAME_LEN(0), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst), .i_data(d_a), .i_valid(v_a), .i_last(l_a),
        .o_ready(rdy_a), .o_accum(acc_a), .o_count(cnt_a), .o_sat(sat_a),
        .o_valid(ov_a), .i_ready(r_a), .o_state(st_a)
    );

    // ---------------- DUT B: FRAME_LEN = 8 ----------------
    logic [NC*IW-1:0] d_b;
    logic             v_b, l_b, r_b, rdy_b, ov_b;
    logic [NC*AW-1:0] acc_b;
    logic [CW-1:0]    cnt_b;
    logic [NC-1:0]    sat_b;
    frame_state_t     st_b;

    accum_corr_mc #(.NUM_CH(NC), .IN_W(IW), .ACC_W(AW), .FRAME_LEN(8), .CNT_W(CW)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_data(d_b), .i_valid(v_b), .i_last(l_b),
        .o_ready(rdy_b), .o_accum(acc_b), .o_count(cnt_b), .o_sat(sat_b),
        .o_valid(ov_b), .i_ready(r_b), .o_state(st_b)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_q[$];   // expected frame counts for DUT B

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NC*IW-1:0] pk(input int x0, input int x1,
                                            input int x2, input int x3);
        return {x3[IW-1:0], x2[IW-1:0], x1[IW-1:0], x0[IW-1:0]};
    endfunction

    function automatic longint lane_a(input int k);
        return longint'($signed(acc_a[k*AW +: AW]));
    endfunction

    function automatic longint lane_b(input int k);
        return longint'($signed(acc_b[k*AW +: AW]));
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [NC*IW-1:0] d, input bit v, input bit l, input bit r);
        d_a = d; v_a = v; l_a = l; r_a = r;
    endtask

    task automatic drive_b(input logic [NC*IW-1:0] d, input bit v, input bit l, input bit r);
        d_b = d; v_b = v; l_b = l; r_b = r;
    endtask

    task automatic chk_result_a(input string name, input longint a0, input longint a1,
                                input longint a2, input longint a3, input int cnt,
                                input logic [3:0] sat);
        chk({name, " lane0"}, lane_a(0), a0);
        chk({name, " lane1"}, lane_a(1), a1);
        chk({name, " lane2"}, lane_a(2), a2);
        chk({name, " lane3"}, lane_a(3), a3);
        chk({name, " count"}, cnt_a, cnt);
        chk({name, " sat"},   sat_a, sat);
    endtask

    // Scoreboard monitor for DUT B (i_ready held high, so o_valid pulses once per frame).
    always @(posedge clk) begin
        #1;
        if (!rst && ov_b) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_result: got count %0d, expected no result", cnt_b);
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                chk("b count", cnt_b, e);
                chk("b lane0", lane_b(0), e);
                chk("b lane3", lane_b(3), e);
                chk("b sat",   sat_b, 0);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int       d0, d1, d2, d3;
        bit       v, l, r;
        bit       e_rdy, e_ov;
        int       a0, a1, a2, a3;
        int       e_cnt;
        bit [3:0] e_sat;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                                input bit v, input bit l, input bit r,
                                input bit e_rdy, input bit e_ov,
                                input int a0, input int a1, input int a2, input int a3,
                                input int e_cnt, input bit [3:0] e_sat);
        vec_t t;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.d3 = d3;
        t.v = v; t.l = l; t.r = r; t.e_rdy = e_rdy; t.e_ov = e_ov;
        t.a0 = a0; t.a1 = a1; t.a2 = a2; t.a3 = a3;
        t.e_cnt = e_cnt; t.e_sat = e_sat;
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        drive_a('0, 0, 0, 1);
        drive_b('0, 0, 0, 1);
        tick();
        tick();

        // reset state
        chk("reset ovalid", ov_a, 0);
        chk("reset accum",  acc_a, 0);
        chk("reset count",  cnt_a, 0);
        chk("reset sat",    sat_a, 0);
        chk("reset ready",  rdy_a, 1);
        chk("reset state",  st_a, ST_IDLE);
        chk("reset b ovalid", ov_b, 0);
        rst = 1'b0;

        //        d0  d1  d2  d3  v l r rdy ov  a0  a1  a2  a3 cnt sat
        // basic 3-sample frame
        vt.push_back(mk( 1, -2, 100, 0, 1,0,1, 1,0,  0,  0,  0,  0, 0, 0));
        vt.push_back(mk( 1, -2, 100, 0, 1,0,1, 1,0,  0,  0,  0,  0, 0, 0));
        vt.push_back(mk( 1, -2, 100, 0, 1,1,1, 1,1,  3, -6, 300, 0, 3, 0));
        vt.push_back(mk( 0,  0,  0, 0, 0,0,1, 1,0,  0,  0,  0,  0, 0, 0));
        // back-to-back frames of length 1,1,2
        vt.push_back(mk( 5,  6,  7, 8, 1,1,1, 1,1,  5,  6,  7,  8, 1, 0));
        vt.push_back(mk(-1, -1, -1,-1, 1,1,1, 1,1, -1, -1, -1, -1, 1, 0));
        vt.push_back(mk( 2,  0,  0, 0, 1,0,1, 1,0,  0,  0,  0,  0, 0, 0));
        vt.push_back(mk( 3,  0,  0, 0, 1,1,1, 1,1,  5,  0,  0,  0, 2, 0));
        vt.push_back(mk( 0,  0,  0, 0, 0,0,1, 1,0,  0,  0,  0,  0, 0, 0));
        // back-pressure
        vt.push_back(mk(10,  0,  0, 0, 1,1,0, 1,1, 10,  0,  0,  0, 1, 0));
        vt.push_back(mk(20,  1,  0, 0, 1,0,0, 0,1, 10,  0,  0,  0, 1, 0));
        vt.push_back(mk(20,  1,  0, 0, 1,0,1, 1,0,  0,  0,  0,  0, 0, 0));
        vt.push_back(mk(30,  2,  0, 0, 1,1,0, 1,1, 50,  3,  0,  0, 2, 0));
        vt.push_back(mk( 4,  4,  4, 4, 1,1,0, 0,1, 50,  3,  0,  0, 2, 0));
        vt.push_back(mk( 4,  4,  4, 4, 1,1,1, 1,1,  4,  4,  4,  4, 1, 0));
        vt.push_back(mk( 0,  0,  0, 0, 0,0,1, 1,0,  0,  0,  0,  0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive_a(pk(vt[i].d0, vt[i].d1, vt[i].d2, vt[i].d3), vt[i].v, vt[i].l, vt[i].r);
            #1;
            chk($sformatf("vec%0d o_ready", i), rdy_a, vt[i].e_rdy);
            tick();
            chk($sformatf("vec%0d o_valid", i), ov_a, vt[i].e_ov);
            if (vt[i].e_ov) begin
                chk_result_a($sformatf("vec%0d", i), vt[i].a0, vt[i].a1, vt[i].a2,
                             vt[i].a3, vt[i].e_cnt, vt[i].e_sat);
            end
        end

        // saturation: lane0 positive, lane1 negative, lane2 unclipped, 40 samples
        for (int i = 0; i < 40; i++) begin
            drive_a(pk(2**24 - 1, -(2**24), 1, 0), 1, (i == 39), 1);
            tick();
            if (i == 0) begin
                chk("sat state accum", st_a, ST_ACCUM);
            end
        end
        chk("sat ovalid", ov_a, 1);
        chk_result_a("sat", 536870911, -536870912, 40, 0, 40, 4'b0011);

        // single-sample frame right after: flags cleared, sign extension
        drive_a(pk(-5, 0, 0, 1), 1, 1, 1);
        tick();
        chk("single ovalid", ov_a, 1);
        chk_result_a("single", -5, 0, 0, 1, 1, 4'b0000);
        chk("single state idle", st_a, ST_IDLE);
        drive_a('0, 0, 0, 1);
        tick();

        // reset mid-frame after 5 samples
        for (int i = 0; i < 5; i++) begin
            drive_a(pk(9, 9, 9, 9), 1, 0, 1);
            tick();
        end
        chk("midrst state accum", st_a, ST_ACCUM);
        drive_a('0, 0, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst state idle", st_a, ST_IDLE);
        for (int i = 0; i < 2; i++) begin
            drive_a(pk(7, 7, 7, 7), 1, (i == 1), 1);
            tick();
        end
        chk("post-rst ovalid", ov_a, 1);
        chk_result_a("post-rst", 14, 14, 14, 14, 2, 4'b0000);

        // hold the result, then reset with o_valid=1
        drive_a('0, 0, 0, 0);
        tick();
        chk("hold ovalid", ov_a, 1);
        chk("hold count", cnt_a, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst-full ovalid", ov_a, 0);
        chk("rst-full count", cnt_a, 0);
        chk("rst-full accum", acc_a, 0);
        drive_a('0, 0, 0, 1);

        // FRAME_LEN=8 on DUT B: 20 samples of 1, no i_last
        exp_q.push_back(16'd8);
        exp_q.push_back(16'd8);
        for (int i = 0; i < 20; i++) begin
            drive_b(pk(1, 1, 1, 1), 1, 0, 1);
            tick();
        end
        drive_b('0, 0, 0, 1);
        tick();
        tick();
        tick();
        chk("b remainder not emitted", ov_b, 0);
        chk("b two frames seen", exp_q.size(), 0);
        chk("b state accum", st_b, ST_ACCUM);
        // i_last flushes the 4-sample remainder plus this sample
        exp_q.push_back(16'd5);
        drive_b(pk(1, 1, 1, 1), 1, 1, 1);
        tick();
        drive_b('0, 0, 0, 1);
        tick();
        tick();
        chk("b remainder frame seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
